interrupt_stack_sequencer: RTL and testbench

Memory-side initiator that drives the data memory port for interrupt entry and return-from-interrupt (RTI). On an accepted interrupt it pushes the PC and the condition-code register (CCR) onto the stack in data memory, then fetches the handler address from the interrupt vector location. On RTI it pops both values back. It sits between the CPU core (PC, CCR and SP registers, stall logic) and the shared data memory read/write port.

---
 rtl/isr_seq_pkg.sv | 17 +
 rtl/interrupt_stack_sequencer.sv | 139 +++++++++++++
 tb/tb_interrupt_stack_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isr_seq_pkg.sv
// Shared constants and state encoding for the interrupt entry / RTI stack sequencer.
package isr_seq_pkg;

  localparam int CCR_W = 4;
  localparam logic [7:0] VEC_ADDR = 8'h01;
  localparam logic [7:0] SP_RESET = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_PC,
    ST_PUSH_CCR,
    ST_FETCH_VEC,
    ST_POP_CCR,
    ST_POP_PC
  } state_t;

endpackage

// File: rtl/interrupt_stack_sequencer.sv
// Drives the data-memory port to push PC/CCR and fetch the vector on interrupt entry,
// and to pop CCR/PC on RTI; every non-IDLE state is a single stall cycle.
module interrupt_stack_sequencer
  import isr_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             int_req,
  input  logic             rti_req,
  input  logic [7:0]       pc_in,
  input  logic [CCR_W-1:0] ccr_in,
  input  logic [7:0]       sp_in,
  output logic             mem_read,
  output logic             mem_write,
  output logic [7:0]       address,
  output logic [7:0]       wdata,
  input  logic [7:0]       rdata,
  output logic             busy,
  output logic             pc_load,
  output logic [7:0]       pc_out,
  output logic             ccr_load,
  output logic [CCR_W-1:0] ccr_out,
  output logic             sp_load,
  output logic [7:0]       sp_out,
  output logic             int_ack,
  output logic             in_isr
);

  state_t           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [7:0]       sp_q, sp_d;
  logic [CCR_W-1:0] ccr_q, ccr_d;
  logic             in_isr_q, in_isr_d;

  // 8-bit adders wrap naturally, giving modulo-256 stack arithmetic.
  logic [7:0] sp_m1, sp_m2, sp_p1, sp_p2;
  assign sp_m1 = sp_q - 8'd1;
  assign sp_m2 = sp_q - 8'd2;
  assign sp_p1 = sp_q + 8'd1;
  assign sp_p2 = sp_q + 8'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= 8'h00;
      sp_q     <= 8'h00;
      ccr_q    <= '0;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      ccr_q    <= ccr_d;
      in_isr_q <= in_isr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    ccr_d     = ccr_q;
    in_isr_d  = in_isr_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    address   = 8'h00;
    wdata     = 8'h00;
    pc_load   = 1'b0;
    pc_out    = 8'h00;
    ccr_load  = 1'b0;
    ccr_out   = '0;
    sp_load   = 1'b0;
    sp_out    = 8'h00;
    int_ack   = 1'b0;
    busy      = (state_q != ST_IDLE);
    in_isr    = in_isr_q;

    case (state_q)
      ST_IDLE: begin
        // RTI wins; a held int_req is simply re-seen on a later IDLE cycle.
        if (rti_req) begin
          state_d = ST_POP_CCR;
          pc_d    = pc_in;
          sp_d    = sp_in;
          ccr_d   = ccr_in;
        end else if (int_req && !in_isr_q) begin
          state_d = ST_PUSH_PC;
          pc_d    = pc_in;
          sp_d    = sp_in;
          ccr_d   = ccr_in;
        end
      end
      ST_PUSH_PC: begin
        mem_write = 1'b1;
        address   = sp_q;
        wdata     = pc_q;
        state_d   = ST_PUSH_CCR;
      end
      ST_PUSH_CCR: begin
        mem_write = 1'b1;
        address   = sp_m1;
        wdata     = {{(8-CCR_W){1'b0}}, ccr_q};
        state_d   = ST_FETCH_VEC;
      end
      ST_FETCH_VEC: begin
        mem_read = 1'b1;
        address  = VEC_ADDR;
        pc_load  = 1'b1;
        pc_out   = rdata;
        sp_load  = 1'b1;
        sp_out   = sp_m2;
        ccr_load = 1'b1;
        ccr_out  = '0;
        int_ack  = 1'b1;
        in_isr_d = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_POP_CCR: begin
        mem_read = 1'b1;
        address  = sp_p1;
        ccr_load = 1'b1;
        ccr_out  = rdata[CCR_W-1:0];
        state_d  = ST_POP_PC;
      end
      ST_POP_PC: begin
        mem_read = 1'b1;
        address  = sp_p2;
        pc_load  = 1'b1;
        pc_out   = rdata;
        sp_load  = 1'b1;
        sp_out   = sp_p2;
        in_isr_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_interrupt_stack_sequencer.sv
// Bench for interrupt_stack_sequencer: stack/memory reference model, vector table, corner sequences, random mix.
module tb_interrupt_stack_sequencer;
  import isr_seq_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             int_req = 1'b0;
  logic             rti_req = 1'b0;
  logic [7:0]       pc_in = 8'h00;
  logic [CCR_W-1:0] ccr_in = '0;
  logic [7:0]       sp_in = 8'h00;
  logic             mem_read, mem_write, busy, pc_load, ccr_load, sp_load, int_ack, in_isr;
  logic [7:0]       address, wdata, pc_out, sp_out;
  logic [7:0]       rdata;
  logic [CCR_W-1:0] ccr_out;

  interrupt_stack_sequencer dut (
    .clk(clk), .rst(rst), .int_req(int_req), .rti_req(rti_req),
    .pc_in(pc_in), .ccr_in(ccr_in), .sp_in(sp_in),
    .mem_read(mem_read), .mem_write(mem_write), .address(address), .wdata(wdata),
    .rdata(rdata), .busy(busy),
    .pc_load(pc_load), .pc_out(pc_out), .ccr_load(ccr_load), .ccr_out(ccr_out),
    .sp_load(sp_load), .sp_out(sp_out), .int_ack(int_ack), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  // Data memory with asynchronous read; the bench can preload bytes through a side port.
  logic [7:0] mem [256] = '{default: 8'h00};
  logic       tb_we = 1'b0;
  logic [7:0] tb_wa = 8'h00, tb_wd = 8'h00;

  always @(posedge clk) begin
    if (mem_write) mem[address] <= wdata;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  always_comb rdata = mem_read ? mem[address] : 8'h00;

  // Reference model: a byte-addressed stack with post-decrement push and pre-increment pop.
  logic [7:0] m_mem [256];
  logic [7:0] m_sp;
  logic       m_isr;

  task automatic m_push(input logic [7:0] v);
    m_mem[m_sp] = v;
    m_sp = m_sp - 8'd1;
  endtask

  task automatic m_pop(output logic [7:0] v);
    m_sp = m_sp + 8'd1;
    v = m_mem[m_sp];
  endtask

  typedef struct packed {
    logic             busy, rd, wr;
    logic [7:0]       addr, wdata;
    logic             pcl;
    logic [7:0]       pco;
    logic             ccrl;
    logic [CCR_W-1:0] ccro;
    logic             spl;
    logic [7:0]       spo;
    logic             ack, isr;
  } obs_t;

  int checks = 0;
  int errors = 0;
  logic [7:0]       last_pc, last_sp;
  logic [CCR_W-1:0] last_ccr;

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy;    o.rd = mem_read;  o.wr = mem_write;
    o.addr = address; o.wdata = wdata;
    o.pcl = pc_load;  o.pco = pc_out;
    o.ccrl = ccr_load; o.ccro = ccr_out;
    o.spl = sp_load;  o.spo = sp_out;
    o.ack = int_ack;  o.isr = in_isr;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t e);
    obs_t a;
    a = sample();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s outputs got %h want %h (t=%0t)", name, a, e, $time);
    end
  endtask

  task automatic cmp8(input string name, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", name, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_obs(input logic isr, output obs_t e);
    e = '0;
    e.isr = isr;
  endtask

  task automatic set_mem(input logic [7:0] a, input logic [7:0] d);
    tb_wa = a; tb_wd = d; tb_we = 1'b1;
    step();
    tb_we = 1'b0;
    m_mem[a] = d;
  endtask

  // Starts in an IDLE cycle, ends in the IDLE cycle after the vector fetch.
  task automatic do_int(input logic [7:0] sp, input logic [7:0] pc, input logic [CCR_W-1:0] ccr);
    obs_t e;
    logic [7:0] a_pc, a_ccr, ccr_byte;
    ccr_byte = {{(8-CCR_W){1'b0}}, ccr};
    sp_in = sp; pc_in = pc; ccr_in = ccr; int_req = 1'b1;
    m_sp = sp;
    a_pc = m_sp;  m_push(pc);
    a_ccr = m_sp; m_push(ccr_byte);
    step();
    pc_in = 8'($urandom); sp_in = 8'($urandom); ccr_in = CCR_W'($urandom);
    e = '0; e.busy = 1'b1; e.wr = 1'b1; e.addr = a_pc; e.wdata = pc; e.isr = m_isr;
    check_obs("int_push_pc", e);
    step();
    e.addr = a_ccr; e.wdata = ccr_byte;
    check_obs("int_push_ccr", e);
    step();
    e = '0; e.busy = 1'b1; e.rd = 1'b1; e.addr = VEC_ADDR;
    e.pcl = 1'b1; e.pco = m_mem[VEC_ADDR]; e.ccrl = 1'b1; e.ccro = '0;
    e.spl = 1'b1; e.spo = m_sp; e.ack = 1'b1; e.isr = m_isr;
    check_obs("int_fetch_vec", e);
    last_pc = pc_out; last_sp = sp_out;
    int_req = 1'b0;
    m_isr = 1'b1;
    step();
    idle_obs(1'b1, e);
    check_obs("int_done_idle", e);
  endtask

  // with_int keeps int_req high alongside the RTI pulse and leaves it high afterwards.
  task automatic do_rti(input logic [7:0] sp, input logic with_int);
    obs_t e;
    logic [7:0] a1, a2, c, p;
    sp_in = sp; pc_in = 8'($urandom); ccr_in = CCR_W'($urandom);
    rti_req = 1'b1; int_req = with_int;
    m_sp = sp;
    a1 = sp + 8'd1; m_pop(c);
    a2 = sp + 8'd2; m_pop(p);
    step();
    rti_req = 1'b0;
    e = '0; e.busy = 1'b1; e.rd = 1'b1; e.addr = a1; e.ccrl = 1'b1; e.ccro = c[CCR_W-1:0]; e.isr = m_isr;
    check_obs("rti_pop_ccr", e);
    last_ccr = ccr_out;
    step();
    e = '0; e.busy = 1'b1; e.rd = 1'b1; e.addr = a2; e.pcl = 1'b1; e.pco = p;
    e.spl = 1'b1; e.spo = m_sp; e.isr = m_isr;
    check_obs("rti_pop_pc", e);
    last_pc = pc_out; last_sp = sp_out;
    m_isr = 1'b0;
    step();
    idle_obs(1'b0, e);
    check_obs("rti_done_idle", e);
  endtask

  task automatic hold_int_in_isr(input int n);
    obs_t e;
    int_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      idle_obs(1'b1, e);
      check_obs("nest_blocked", e);
    end
  endtask

  typedef struct {
    logic [7:0]       sp;
    logic [7:0]       pc;
    logic [CCR_W-1:0] ccr;
    logic [7:0]       vec;
    logic [7:0]       exp_sp;
    logic [7:0]       exp_a_ccr;
    logic [7:0]       exp_ccr_byte;
  } vec_t;

  vec_t tbl [4];

  initial begin
    obs_t e;
    int   r;
    logic w;

    tbl[0] = '{SP_RESET, 8'h20, 4'b1010, 8'h80, 8'hFD, 8'hFE, 8'h0A};
    tbl[1] = '{8'h00,    8'h33, 4'b0101, 8'h44, 8'hFE, 8'hFF, 8'h05};
    tbl[2] = '{8'h80,    8'h7E, 4'b1111, 8'hC3, 8'h7E, 8'h7F, 8'h0F};
    tbl[3] = '{8'h10,    8'h01, 4'b0000, 8'h02, 8'h0E, 8'h0F, 8'h00};

    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_sp = 8'h00;
    m_isr = 1'b0;

    repeat (3) step();
    idle_obs(1'b0, e);
    check_obs("reset_state", e);
    rst = 1'b0;
    step();
    check_obs("idle_after_reset", e);

    // Entry then return for each table row; constants in the row are the required results.
    for (int i = 0; i < 4; i++) begin
      set_mem(VEC_ADDR, tbl[i].vec);
      do_int(tbl[i].sp, tbl[i].pc, tbl[i].ccr);
      cmp8("tbl_vec_pc", last_pc, tbl[i].vec);
      cmp8("tbl_int_sp", last_sp, tbl[i].exp_sp);
      cmp8("tbl_mem_pc", mem[tbl[i].sp], tbl[i].pc);
      cmp8("tbl_mem_ccr", mem[tbl[i].exp_a_ccr], tbl[i].exp_ccr_byte);
      do_rti(tbl[i].exp_sp, 1'b0);
      cmp8("tbl_rti_ccr", {4'h0, last_ccr}, {4'h0, tbl[i].ccr});
      cmp8("tbl_rti_pc", last_pc, tbl[i].pc);
      cmp8("tbl_rti_sp", last_sp, tbl[i].sp);
    end

    // RTI and int_req together: RTI first, interrupt one idle cycle later.
    do_rti(8'h90, 1'b1);
    do_int(8'hA0, 8'h55, 4'b0110);
    cmp8("prio_int_sp", last_sp, 8'h9E);

    // int_req while in the handler waits for RTI, then is taken back-to-back.
    hold_int_in_isr(3);
    do_rti(m_sp, 1'b1);
    cmp8("nest_rti_sp", last_sp, 8'hA0);
    do_int(8'hC0, 8'h66, 4'b0011);
    do_rti(m_sp, 1'b0);
    cmp8("nest_ret_pc", last_pc, 8'h66);

    // Reset while PUSH_CCR is on the port.
    sp_in = 8'h40; pc_in = 8'h5A; ccr_in = 4'h3; int_req = 1'b1;
    m_sp = 8'h40; m_push(8'h5A); m_push(8'h03);
    step();
    int_req = 1'b0;
    step();
    e = '0; e.busy = 1'b1; e.wr = 1'b1; e.addr = 8'h3F; e.wdata = 8'h03;
    check_obs("rst_pre_push_ccr", e);
    rst = 1'b1;
    step();
    idle_obs(1'b0, e);
    check_obs("rst_mid_seq", e);
    cmp8("rst_kept_pc_byte", mem[8'h40], 8'h5A);
    cmp8("rst_kept_ccr_byte", mem[8'h3F], 8'h03);
    rst = 1'b0;
    m_isr = 1'b0;
    step();
    check_obs("rst_after_idle", e);

    // Random mix of entries, plain returns and blocked nested requests.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 3);
      if (!m_isr) begin
        if (r == 0) begin
          do_rti(8'($urandom), 1'b0);
        end else begin
          if (r == 1) set_mem(VEC_ADDR, 8'($urandom));
          do_int(8'($urandom), 8'($urandom), CCR_W'($urandom));
        end
      end else begin
        if (r == 0) hold_int_in_isr($urandom_range(1, 3));
        w = 1'($urandom_range(0, 1));
        do_rti(m_sp, w);
        if (w) do_int(8'($urandom), 8'($urandom), CCR_W'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
